mips_hazard_stall_unit: RTL and testbench

MIPS_HAZARD_STALL_UNIT -- requirements
Module: mips_hazard_stall_unit

---
 rtl/mips_pkg.sv | 30 +++
 rtl/mips_hazard_stall_unit_if.sv | 23 ++
 rtl/mips_instr_decode.sv | 63 ++++++
 rtl/mips_hazard_stall_unit.sv | 103 ++++++++++
 tb/tb_mips_hazard_stall_unit.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS hazard stall unit.
package mips_pkg;

   localparam int unsigned INSTR_W = 32;
   localparam int unsigned REG_W   = 5;
   localparam int unsigned CNT_W   = 16;

   localparam logic [INSTR_W-1:0] NOP_WORD_DEF = 32'h0C631800;

   localparam logic [5:0] OP_RR_LAST  = 6'h05;
   localparam logic [5:0] OP_LW       = 6'h08;
   localparam logic [5:0] OP_SW       = 6'h09;
   localparam logic [5:0] OP_RM_FIRST = 6'h0A;
   localparam logic [5:0] OP_RM_LAST  = 6'h0C;
   localparam logic [5:0] OP_BNEQZ    = 6'h0D;
   localparam logic [5:0] OP_BEQZ     = 6'h0E;
   localparam logic [5:0] OP_HLT      = 6'h30;

   typedef struct packed {
      logic             valid;
      logic [REG_W-1:0] dest;
      logic             is_load;
   } sb_entry_t;

   typedef enum logic {
      RUN  = 1'b0,
      HALT = 1'b1
   } state_t;

endpackage

// File: rtl/mips_hazard_stall_unit_if.sv
// Fetch-side and decode-side handshakes of the hazard stall unit.
interface mips_hazard_stall_unit_if;
   import mips_pkg::*;

   logic               in_valid;
   logic [INSTR_W-1:0] in_instr;
   logic               in_ready;
   logic               out_valid;
   logic [INSTR_W-1:0] out_instr;
   logic               out_ready;
   logic               out_bubble;

   modport master (
      output in_valid, in_instr, out_ready,
      input  in_ready, out_valid, out_instr, out_bubble
   );

   modport slave (
      input  in_valid, in_instr, out_ready,
      output in_ready, out_valid, out_instr, out_bubble
   );

endinterface

// File: rtl/mips_instr_decode.sv
// Combinational field extraction: which sources are read, which register is written.
module mips_instr_decode
   import mips_pkg::*;
(
   input  logic [20:0]      hdr,
   output logic [REG_W-1:0] src1_c,
   output logic [REG_W-1:0] src2_c,
   output logic             src1_used_c,
   output logic             src2_used_c,
   output logic [REG_W-1:0] dest_c,
   output logic             dest_valid_c,
   output logic             is_load_c,
   output logic             is_hlt_c
);

   logic [5:0]       opcode;
   logic [REG_W-1:0] rs, rt, rd;
   logic             reads_rs, reads_rt, writes;

   assign opcode = hdr[20:15];
   assign rs     = hdr[14:10];
   assign rt     = hdr[9:5];
   assign rd     = hdr[4:0];

   always_comb begin
      reads_rs  = 1'b0;
      reads_rt  = 1'b0;
      writes    = 1'b0;
      dest_c    = '0;
      is_load_c = 1'b0;
      is_hlt_c  = 1'b0;
      if (opcode <= OP_RR_LAST) begin
         reads_rs = 1'b1;
         reads_rt = 1'b1;
         writes   = 1'b1;
         dest_c   = rd;
      end else if (opcode >= OP_RM_FIRST && opcode <= OP_RM_LAST) begin
         reads_rs = 1'b1;
         writes   = 1'b1;
         dest_c   = rt;
      end else if (opcode == OP_LW) begin
         reads_rs  = 1'b1;
         writes    = 1'b1;
         dest_c    = rt;
         is_load_c = 1'b1;
      end else if (opcode == OP_SW) begin
         reads_rs = 1'b1;
         reads_rt = 1'b1;
      end else if (opcode == OP_BNEQZ || opcode == OP_BEQZ) begin
         reads_rs = 1'b1;
      end else if (opcode == OP_HLT) begin
         is_hlt_c = 1'b1;
      end
   end

   // R0 is hard-wired zero: it never produces nor consumes a dependency.
   assign src1_c       = rs;
   assign src2_c       = rt;
   assign src1_used_c  = reads_rs && (rs != '0);
   assign src2_used_c  = reads_rt && (rt != '0);
   assign dest_valid_c = writes && (dest_c != '0);

endmodule

// File: rtl/mips_hazard_stall_unit.sv
// Issue-stage interlock: holds fetch and issues NOP bubbles while a source is in flight.
// Define MIPS_HAZ_FWD_EN to stall only on load-use against the newest issued instruction.
module mips_hazard_stall_unit
   import mips_pkg::*;
#(
   parameter int unsigned        PIPE_DEPTH = 3,
   parameter logic [INSTR_W-1:0] NOP_WORD   = NOP_WORD_DEF
) (
   input  logic                           clk1,
   input  logic                           reset,
   mips_hazard_stall_unit_if.slave        bus,
   output logic                           halted,
   output logic [CNT_W-1:0]               stall_count
);

   state_t             state;
   sb_entry_t          sb [PIPE_DEPTH];
   logic               out_valid, out_bubble;
   logic [INSTR_W-1:0] out_instr;

   logic [REG_W-1:0] src1, src2, dest;
   logic             src1_used, src2_used, dest_valid, is_load, is_hlt;
   sb_entry_t        new_entry;
   logic             match, hazard, load_en, xfer;

   mips_instr_decode u_decode (
      .hdr          (bus.in_instr[31:11]),
      .src1_c       (src1),
      .src2_c       (src2),
      .src1_used_c  (src1_used),
      .src2_used_c  (src2_used),
      .dest_c       (dest),
      .dest_valid_c (dest_valid),
      .is_load_c    (is_load),
      .is_hlt_c     (is_hlt)
   );

   function automatic logic hits(input sb_entry_t e, input logic u1, input logic [REG_W-1:0] s1,
                                 input logic u2, input logic [REG_W-1:0] s2);
      return e.valid && ((u1 && (s1 == e.dest)) || (u2 && (s2 == e.dest)));
   endfunction

   // Entry 0 tracks the word sitting in the output register; older entries age on transfers.
   always_comb begin
      match = 1'b0;
`ifdef MIPS_HAZ_FWD_EN
      match = sb[0].is_load && hits(sb[0], src1_used, src1, src2_used, src2);
`else
      for (int unsigned i = 0; i < PIPE_DEPTH; i++) begin
         if (hits(sb[i], src1_used, src1, src2_used, src2)) match = 1'b1;
      end
`endif
   end

   assign new_entry = '{valid: dest_valid, dest: dest, is_load: is_load};
   assign xfer      = out_valid && bus.out_ready;
   assign load_en   = !out_valid || bus.out_ready;
   assign hazard    = bus.in_valid && match && (state == RUN);
   assign bus.in_ready = !reset && (state == RUN) && load_en && !hazard;

   assign bus.out_valid  = out_valid;
   assign bus.out_instr  = out_instr;
   assign bus.out_bubble = out_bubble;

   always_ff @(posedge clk1) begin
      if (reset) begin
         state       <= RUN;
         out_valid   <= 1'b0;
         out_instr   <= NOP_WORD;
         out_bubble  <= 1'b0;
         halted      <= 1'b0;
         stall_count <= '0;
         for (int unsigned i = 0; i < PIPE_DEPTH; i++) sb[i] <= '0;
      end else begin
         if (xfer && out_bubble && (stall_count != {CNT_W{1'b1}}))
            stall_count <= stall_count + CNT_W'(1);
         if (load_en) begin
            if (xfer || (state == HALT)) begin
               for (int unsigned i = 1; i < PIPE_DEPTH; i++) sb[i] <= sb[i-1];
            end
            sb[0]      <= '0;
            out_valid  <= 1'b0;
            out_bubble <= 1'b0;
            if (state == RUN) begin
               if (hazard) begin
                  out_instr  <= NOP_WORD;
                  out_valid  <= 1'b1;
                  out_bubble <= 1'b1;
               end else if (bus.in_valid) begin
                  out_instr <= bus.in_instr;
                  out_valid <= 1'b1;
                  sb[0]     <= new_entry;
                  if (is_hlt) begin
                     state  <= HALT;
                     halted <= 1'b1;
                  end
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_mips_hazard_stall_unit.sv
// Directed bench for mips_hazard_stall_unit (PIPE_DEPTH=3), honours MIPS_HAZ_FWD_EN.
module tb_mips_hazard_stall_unit;
   import mips_pkg::*;

   localparam logic [31:0] NOP       = 32'h0C631800;
   localparam logic [31:0] ADDI_R1   = 32'h28010078;
   localparam logic [31:0] LW_R2     = 32'h20220000;
   localparam logic [31:0] ADDI_R2   = 32'h2842002D;
   localparam logic [31:0] ADDI_TOR0 = 32'h28000005;
   localparam logic [31:0] ADDI_FR0  = 32'h28010000;
   localparam logic [31:0] HLT       = 32'hC0000000;

   logic        clk1 = 1'b0;
   logic        reset;
   logic        halted;
   logic [15:0] stall_count;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;
   logic [31:0] fetch_q[$];
   logic [32:0] obs_q[$];
   logic [32:0] exp_q[$];

   mips_hazard_stall_unit_if bus ();

   mips_hazard_stall_unit #(.PIPE_DEPTH(3), .NOP_WORD(NOP)) dut (
      .clk1        (clk1),
      .reset       (reset),
      .bus         (bus),
      .halted      (halted),
      .stall_count (stall_count)
   );

   always #5 clk1 = ~clk1;

   task automatic chk(input string tag, input logic [32:0] got, input logic [32:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk1);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_instr = ADDI_R1;
      bus.out_ready = 1'b1;
      @(negedge clk1);
      chk("rst_in_ready", 33'(bus.in_ready), 33'(0));
      tick();
      chk("rst_out_valid", 33'(bus.out_valid), 33'(0));
      chk("rst_out_instr", 33'(bus.out_instr), 33'(NOP));
      chk("rst_out_bubble", 33'(bus.out_bubble), 33'(0));
      chk("rst_halted", 33'(halted), 33'(0));
      chk("rst_stall_count", 33'(stall_count), 33'(0));
      reset = 1'b0;
      bus.in_valid = 1'b0;
   endtask

   // Presents fetch_q in order with out_ready=1, logging every output transfer.
   task automatic drain(input int unsigned budget);
      int unsigned cyc = 0;
      logic acc;
      logic done = 1'b0;
      obs_q.delete();
      bus.out_ready = 1'b1;
      while (!done && cyc < budget) begin
         bus.in_valid = (fetch_q.size() != 0);
         bus.in_instr = (fetch_q.size() != 0) ? fetch_q[0] : 32'h0;
         @(negedge clk1);
         acc = bus.in_valid && bus.in_ready;
         if (bus.out_valid && bus.out_ready) obs_q.push_back({bus.out_bubble, bus.out_instr});
         tick();
         if (acc) void'(fetch_q.pop_front());
         cyc++;
         done = (fetch_q.size() == 0) && !bus.out_valid;
      end
      chk("drain_done", 33'(done), 33'(1));
      bus.in_valid = 1'b0;
   endtask

   task automatic push_word(input logic [31:0] w);
      exp_q.push_back({1'b0, w});
   endtask

   task automatic push_bubble();
      exp_q.push_back({1'b1, NOP});
   endtask

   task automatic cmp_stream(input string tag);
      chk({tag, "_len"}, 33'(obs_q.size()), 33'(exp_q.size()));
      foreach (exp_q[i])
         chk($sformatf("%s_%0d", tag, i), (i < obs_q.size()) ? obs_q[i] : 33'h0, exp_q[i]);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_instr  = 32'h0;
      bus.out_ready = 1'b1;
      do_reset();

      // ADDI R1 -> LW R2,[R1] -> ADDI R2,R2
      fetch_q.delete();
      fetch_q.push_back(ADDI_R1);
      fetch_q.push_back(LW_R2);
      fetch_q.push_back(ADDI_R2);
      drain(60);
      exp_q.delete();
      push_word(ADDI_R1);
`ifdef MIPS_HAZ_FWD_EN
      push_word(LW_R2);
      push_bubble();
      push_word(ADDI_R2);
      cmp_stream("raw");
      chk("raw_stalls", 33'(stall_count), 33'(1));
`else
      repeat (3) push_bubble();
      push_word(LW_R2);
      repeat (3) push_bubble();
      push_word(ADDI_R2);
      cmp_stream("raw");
      chk("raw_stalls", 33'(stall_count), 33'(6));
`endif

      // R0 as destination then as source never interlocks
      do_reset();
      fetch_q.delete();
      fetch_q.push_back(ADDI_TOR0);
      fetch_q.push_back(ADDI_FR0);
      drain(20);
      exp_q.delete();
      push_word(ADDI_TOR0);
      push_word(ADDI_FR0);
      cmp_stream("r0");
      chk("r0_stalls", 33'(stall_count), 33'(0));

      // Decode back-pressure in the middle of a load-use stall
      do_reset();
      bus.in_valid = 1'b1;
      bus.in_instr = LW_R2;
      @(negedge clk1);
      chk("bp_lw_ready", 33'(bus.in_ready), 33'(1));
      tick();
      chk("bp_lw_out", 33'(bus.out_instr), 33'(LW_R2));
      bus.in_instr = ADDI_R2;
      @(negedge clk1);
      chk("bp_haz_ready", 33'(bus.in_ready), 33'(0));
      tick();
      chk("bp_bubble", 33'({bus.out_bubble, bus.out_instr}), {1'b1, NOP});
      bus.out_ready = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk1);
         chk($sformatf("bp_hold_out_%0d", c), 33'({bus.out_bubble, bus.out_instr}), {1'b1, NOP});
         chk($sformatf("bp_hold_valid_%0d", c), 33'(bus.out_valid), 33'(1));
         chk($sformatf("bp_hold_ready_%0d", c), 33'(bus.in_ready), 33'(0));
         chk($sformatf("bp_hold_cnt_%0d", c), 33'(stall_count), 33'(0));
         tick();
      end
      fetch_q.delete();
      fetch_q.push_back(ADDI_R2);
      drain(20);
      exp_q.delete();
`ifdef MIPS_HAZ_FWD_EN
      push_bubble();
      push_word(ADDI_R2);
      cmp_stream("bp");
      chk("bp_stalls", 33'(stall_count), 33'(1));
`else
      repeat (3) push_bubble();
      push_word(ADDI_R2);
      cmp_stream("bp");
      chk("bp_stalls", 33'(stall_count), 33'(3));
`endif

      // HLT freezes issue until reset; stall_count is nonzero going in
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_instr  = HLT;
      @(negedge clk1);
      chk("hlt_ready", 33'(bus.in_ready), 33'(1));
      chk("hlt_halted_before", 33'(halted), 33'(0));
      tick();
      chk("hlt_halted", 33'(halted), 33'(1));
      chk("hlt_out", 33'({bus.out_valid, bus.out_instr}), {1'b1, HLT});
      bus.in_instr = ADDI_R1;
      @(negedge clk1);
      chk("hlt_ready_after", 33'(bus.in_ready), 33'(0));
      tick();
      for (int c = 0; c < 3; c++) begin
         @(negedge clk1);
         chk($sformatf("halt_valid_%0d", c), 33'(bus.out_valid), 33'(0));
         chk($sformatf("halt_ready_%0d", c), 33'(bus.in_ready), 33'(0));
         chk($sformatf("halt_flag_%0d", c), 33'(halted), 33'(1));
         tick();
      end
      do_reset();
      bus.in_valid = 1'b1;
      bus.in_instr = ADDI_R1;
      @(negedge clk1);
      chk("post_rst_ready", 33'(bus.in_ready), 33'(1));
      tick();
      chk("post_rst_out", 33'({bus.out_valid, bus.out_instr}), {1'b1, ADDI_R1});
      bus.in_valid = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
